// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial ripple adder with valid/ready handshakes
// One full-adder cell is reused LSB-first over WIDTH shift cycles.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             carry;
  logic             cout_reg;
  logic [CW-1:0]    cnt;

  logic ha0_s;
  logic ha0_c;
  logic ha1_c;
  logic bit_s;
  logic bit_c;
  logic last_bit;
  logic accept;

  // Full-adder cell built from two half adders and an OR
  assign ha0_s    = a_reg[0] ^ b_reg[0];
  assign ha0_c    = a_reg[0] & b_reg[0];
  assign bit_s    = ha0_s ^ carry;
  assign ha1_c    = ha0_s & carry;
  assign bit_c    = ha0_c | ha1_c;
  assign last_bit = (cnt == CW'(WIDTH - 1));
  assign accept   = (state == IDLE) && in_valid;

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_nxt = SHIFT;
      end
      SHIFT: begin
        if (last_bit) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      a_reg    <= '0;
      b_reg    <= '0;
      sum_reg  <= '0;
      carry    <= 1'b0;
      cout_reg <= 1'b0;
      cnt      <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        a_reg <= a;
        b_reg <= b;
        carry <= cin;
        cnt   <= '0;
      end else if (state == SHIFT) begin
        sum_reg <= {bit_s, sum_reg[WIDTH-1:1]};
        a_reg   <= a_reg >> 1;
        b_reg   <= b_reg >> 1;
        carry   <= bit_c;
        // Counter wraps to zero on the final bit so it never reaches WIDTH
        if (last_bit) begin
          cout_reg <= bit_c;
          cnt      <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

  assign sum  = sum_reg;
  assign cout = cout_reg;

endmodule

// File: doc/serial_adder_ctrl.md
SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 Parameter: WIDTH, 8, operand width in bits; legal range 2..32.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset; synchronous and active-high.
REQ-004 Port: in_valid  input  1  requester offers operands.
REQ-005 Port: in_ready  output  1  block accepts operands this cycle.
REQ-006 Port: a  input  WIDTH  addend A.
REQ-007 Port: b  input  WIDTH  addend B.
REQ-008 Port: cin  input  1  carry-in.
REQ-009 Port: out_valid  output  1  sum and cout hold a completed result.
REQ-010 Port: out_ready  input  1  consumer takes the result.
REQ-011 Port: sum  output  WIDTH  result bits.
REQ-012 Port: cout  output  1  carry out of bit WIDTH-1.
REQ-013 Port: busy  output  1  high whenever state is not IDLE.

Function
REQ-014 The block SHALL sequence one 1-bit full-adder cell (two half adders plus OR) over WIDTH cycles, LSB first.
REQ-015 FSM states SHALL be IDLE, SHIFT and DONE; any unused encoding SHALL return to IDLE on the next edge.
REQ-016 IDLE: in_ready=1; on an edge with in_valid=1, the block SHALL capture a, b and cin into internal registers, clear the bit counter and enter SHIFT.
REQ-017 SHIFT: each edge SHALL compute s=a0^b0^c, c'=a0&b0 | c&(a0^b0), shift s into the MSB of the sum register, shift the operand registers right, and increment the counter.
REQ-018 SHIFT SHALL exit to DONE on the edge that processes bit WIDTH-1 (counter==WIDTH-1); cout SHALL take the final carry on that edge.
REQ-019 Latency: out_valid SHALL rise exactly WIDTH edges after the accept edge.
REQ-020 DONE: out_valid=1; sum and cout SHALL remain stable until the edge where out_ready=1, which returns the FSM to IDLE.
REQ-021 in_ready SHALL be 0 in SHIFT and DONE; in_valid and operand changes there SHALL be ignored.
REQ-022 Minimum issue interval SHALL be WIDTH+2 cycles (accept, WIDTH shifts, DONE handshake).
REQ-023 Arithmetic: {cout,sum} SHALL equal a+b+cin of the captured operands; sum wraps modulo 2^WIDTH.
REQ-024 Outside DONE, sum/cout SHALL be treated as undefined by consumers; the sum register SHALL change only in SHIFT.
REQ-025 The bit counter SHALL be ceil(log2(WIDTH)) bits wide and never exceed WIDTH-1.

Reset
REQ-026 rst SHALL take priority over every other input on the same edge.
REQ-027 After a reset edge: state=IDLE, in_ready=1, out_valid=0, busy=0, sum=0, cout=0, counter=0, operand and carry registers 0.
REQ-028 Reset during SHIFT or DONE SHALL discard the operation with no out_valid pulse.

Verification
REQ-029 Reset, WIDTH=8: hold rst 2 cycles -> in_ready=1, out_valid=0, busy=0, sum=0x00, cout=0.
REQ-030 a=0x0F, b=0x01, cin=0 accepted -> out_valid rises exactly 8 edges later with sum=0x10, cout=0; busy=1 throughout.
REQ-031 a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
REQ-032 out_ready=0 for 5 cycles in DONE -> out_valid, sum and cout stay constant and in_ready=0; out_ready=1 -> IDLE next edge.
REQ-033 rst on the 4th SHIFT edge -> IDLE next cycle, no out_valid; next op a=0x12, b=0x34, cin=0 -> sum=0x46, cout=0.
REQ-034 WIDTH=4 exhaustive: all 512 (a,b,cin) with in_valid toggled and operands randomized while busy -> every result matches the captured a+b+cin.
